// File: rtl/load_store_unit.sv
// Load/store unit: turns one load or store per transaction into req/gnt/rvalid
// bus beats with byte strobes, splitting boundary-crossing accesses into two
// beats when MISALIGN_SPLIT=1, and returns extended load data to writeback.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a new operation; operands captured on accept
// REQ0   | first (or only) beat requested, held until granted
// WAIT0  | first beat granted, waiting for its response
// REQ1   | second beat of a split access requested
// WAIT1  | second beat granted, waiting for its response
// DONE   | one-cycle completion pulse with result / exception
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_SPLIT = 1'b0
) (
    input  logic                i_Clk_1,
    input  logic                i_Rst_n_1,
    input  logic                i_Valid_1,
    output logic                o_Ready_1,
    input  logic                i_Load_1,
    input  logic                i_Store_1,
    input  logic                i_LoadUnsigned_1,
    input  logic [1:0]          i_LoadStoreWidth_2,
    input  logic [XLEN-1:0]     i_ALUResult_XLEN,
    input  logic [XLEN-1:0]     i_StoreData_XLEN,
    output logic                o_Done_1,
    output logic [XLEN-1:0]     o_GRFWriteData_XLEN,
    output logic                o_Exception_1,
    output logic [1:0]          o_ExcCode_2,
    output logic                o_MemReq_1,
    output logic                o_MemWriteEnable_1,
    output logic [ADDR_W-1:0]   o_MemAddr_ADDR_W,
    output logic [XLEN-1:0]     o_MemStoreData_XLEN,
    output logic [XLEN/8-1:0]   o_MemStrb_XLEN8,
    input  logic                i_MemGnt_1,
    input  logic                i_MemRvalid_1,
    input  logic [XLEN-1:0]     i_MemLoadData_XLEN
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [XLEN-1:0]     rbuf_q, rbuf_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [1:0]          width_q, width_d;
    logic [1:0]          code_q, code_d;
    logic                load_q, load_d;
    logic                store_q, store_d;
    logic                uns_q, uns_d;
    logic                exc_q, exc_d;

    logic [OFF_W-1:0]    in_off;
    logic [3:0]          in_bytes;
    logic                in_mis, in_cross;

    logic [OFF_W-1:0]    off;
    logic [OFF_W+2:0]    sh;
    logic [2*NB-1:0]     mask_w, strb_w;
    logic [2*XLEN-1:0]   wdata_w, rdata_w;
    logic [XLEN-1:0]     rd_lo, rd_hi, raw, keep, ld_ext;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic                split, sign, in_req, beat1;

    // Alignment classification of the operation being presented.
    always_comb begin
        in_off   = i_ALUResult_XLEN[OFF_W-1:0];
        in_bytes = 4'd1 << i_LoadStoreWidth_2;
        in_mis   = |(i_ALUResult_XLEN[3:0] & (in_bytes - 4'd1));
        in_cross = (int'(in_off) + int'(in_bytes)) > NB;
    end

    // Lane placement of the captured access and extension of returned data.
    always_comb begin
        off = addr_q[OFF_W-1:0];
        sh  = {off, 3'b000};
        case (width_q)
            2'b00:   mask_w = (2*NB)'(8'h01);
            2'b01:   mask_w = (2*NB)'(8'h03);
            2'b10:   mask_w = (2*NB)'(8'h0F);
            default: mask_w = (2*NB)'(8'hFF);
        endcase
        strb_w  = mask_w << off;
        wdata_w = {{XLEN{1'b0}}, data_q} << sh;
        split   = |strb_w[2*NB-1:NB];
        addr0   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        addr1   = addr0 + ADDR_W'(NB);

        // The second beat's data lands above the bytes taken from the first.
        rd_lo   = (state_q == S_WAIT1) ? rbuf_q : i_MemLoadData_XLEN;
        rd_hi   = (state_q == S_WAIT1) ? i_MemLoadData_XLEN : '0;
        rdata_w = {rd_hi, rd_lo} >> sh;
        raw     = rdata_w[XLEN-1:0];
        case (width_q)
            2'b00:   begin keep = XLEN'(8'hFF);         sign = raw[7];      end
            2'b01:   begin keep = XLEN'(16'hFFFF);      sign = raw[15];     end
            2'b10:   begin keep = XLEN'(32'hFFFF_FFFF); sign = raw[31];     end
            default: begin keep = '1;                   sign = raw[XLEN-1]; end
        endcase
        ld_ext = (raw & keep) | ({XLEN{sign & ~uns_q}} & ~keep);
    end

    // Next-state and captured-operand update.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rbuf_d   = rbuf_q;
        result_d = result_q;
        width_d  = width_q;
        code_d   = code_q;
        load_d   = load_q;
        store_d  = store_q;
        uns_d    = uns_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE: begin
                if (i_Valid_1) begin
                    addr_d   = i_ALUResult_XLEN[ADDR_W-1:0];
                    data_d   = i_StoreData_XLEN;
                    width_d  = i_LoadStoreWidth_2;
                    load_d   = i_Load_1;
                    store_d  = i_Store_1 & ~i_Load_1;
                    uns_d    = i_LoadUnsigned_1;
                    result_d = '0;
                    exc_d    = 1'b0;
                    code_d   = 2'b00;
                    state_d  = S_DONE;
                    if (!(i_Load_1 || i_Store_1)) begin
                        result_d = i_ALUResult_XLEN;
                    end else if (XLEN == 32 && i_LoadStoreWidth_2 == 2'b11) begin
                        exc_d  = 1'b1;
                        code_d = 2'b11;
                    end else if ((!MISALIGN_SPLIT && in_mis) ||
                                 (i_LoadStoreWidth_2 == 2'b11 && in_cross)) begin
                        exc_d  = 1'b1;
                        code_d = i_Load_1 ? 2'b01 : 2'b10;
                    end else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: if (i_MemGnt_1) state_d = S_WAIT0;
            S_WAIT0: begin
                if (i_MemRvalid_1) begin
                    rbuf_d = i_MemLoadData_XLEN;
                    if (split) begin
                        state_d = S_REQ1;
                    end else begin
                        result_d = load_q ? ld_ext : '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_REQ1: if (i_MemGnt_1) state_d = S_WAIT1;
            S_WAIT1: begin
                if (i_MemRvalid_1) begin
                    result_d = load_q ? ld_ext : '0;
                    state_d  = S_DONE;
                end
            end
            default: begin
                result_d = '0;
                exc_d    = 1'b0;
                code_d   = 2'b00;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and operand registers; reset clears everything immediately.
    always_ff @(posedge i_Clk_1 or negedge i_Rst_n_1) begin
        if (!i_Rst_n_1) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            rbuf_q   <= '0;
            result_q <= '0;
            width_q  <= 2'b00;
            code_q   <= 2'b00;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            uns_q    <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rbuf_q   <= rbuf_d;
            result_q <= result_d;
            width_q  <= width_d;
            code_q   <= code_d;
            load_q   <= load_d;
            store_q  <= store_d;
            uns_q    <= uns_d;
            exc_q    <= exc_d;
        end
    end

    // Bus and writeback outputs; bus fields are zero outside request states.
    always_comb begin
        in_req              = (state_q == S_REQ0) || (state_q == S_REQ1);
        beat1               = (state_q == S_REQ1);
        o_Ready_1           = (state_q == S_IDLE);
        o_Done_1            = (state_q == S_DONE);
        o_GRFWriteData_XLEN = o_Done_1 ? result_q : '0;
        o_Exception_1       = o_Done_1 & exc_q;
        o_ExcCode_2         = o_Done_1 ? code_q : 2'b00;
        o_MemReq_1          = in_req;
        o_MemWriteEnable_1  = in_req & store_q;
        o_MemAddr_ADDR_W    = '0;
        o_MemStrb_XLEN8     = '0;
        o_MemStoreData_XLEN = '0;
        if (in_req) begin
            o_MemAddr_ADDR_W    = beat1 ? addr1 : addr0;
            o_MemStrb_XLEN8     = beat1 ? strb_w[2*NB-1:NB] : strb_w[NB-1:0];
            o_MemStoreData_XLEN = beat1 ? wdata_w[2*XLEN-1:XLEN] : wdata_w[XLEN-1:0];
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: three instances (32-bit trapping, 32-bit
// splitting, 64-bit splitting) driven from a table of operations; expected
// bus beats and completions go into queues as each operation is issued.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        valid [3], load [3], store [3], uns [3], gnt [3], rvalid [3];
    logic [1:0]  width [3];
    logic [63:0] alu [3], sdata [3], rdata [3];

    logic        ready [3], done [3], exc [3], req [3], we [3];
    logic [1:0]  code [3];
    logic [31:0] maddr [3];
    logic [63:0] grf [3], mwdata [3];
    logic [7:0]  strb [3];

    logic [31:0] grf0, grf1, mwd0, mwd1;
    logic [63:0] grf2, mwd2;
    logic [3:0]  strb0, strb1;
    logic [7:0]  strb2;

    assign grf[0] = {32'h0, grf0};
    assign grf[1] = {32'h0, grf1};
    assign grf[2] = grf2;
    assign mwdata[0] = {32'h0, mwd0};
    assign mwdata[1] = {32'h0, mwd1};
    assign mwdata[2] = mwd2;
    assign strb[0] = {4'h0, strb0};
    assign strb[1] = {4'h0, strb1};
    assign strb[2] = strb2;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_dut0 (
        .i_Clk_1(clk), .i_Rst_n_1(rst_n), .i_Valid_1(valid[0]), .o_Ready_1(ready[0]),
        .i_Load_1(load[0]), .i_Store_1(store[0]), .i_LoadUnsigned_1(uns[0]),
        .i_LoadStoreWidth_2(width[0]), .i_ALUResult_XLEN(alu[0][31:0]),
        .i_StoreData_XLEN(sdata[0][31:0]), .o_Done_1(done[0]), .o_GRFWriteData_XLEN(grf0),
        .o_Exception_1(exc[0]), .o_ExcCode_2(code[0]), .o_MemReq_1(req[0]),
        .o_MemWriteEnable_1(we[0]), .o_MemAddr_ADDR_W(maddr[0]), .o_MemStoreData_XLEN(mwd0),
        .o_MemStrb_XLEN8(strb0), .i_MemGnt_1(gnt[0]), .i_MemRvalid_1(rvalid[0]),
        .i_MemLoadData_XLEN(rdata[0][31:0]));

    load_store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut1 (
        .i_Clk_1(clk), .i_Rst_n_1(rst_n), .i_Valid_1(valid[1]), .o_Ready_1(ready[1]),
        .i_Load_1(load[1]), .i_Store_1(store[1]), .i_LoadUnsigned_1(uns[1]),
        .i_LoadStoreWidth_2(width[1]), .i_ALUResult_XLEN(alu[1][31:0]),
        .i_StoreData_XLEN(sdata[1][31:0]), .o_Done_1(done[1]), .o_GRFWriteData_XLEN(grf1),
        .o_Exception_1(exc[1]), .o_ExcCode_2(code[1]), .o_MemReq_1(req[1]),
        .o_MemWriteEnable_1(we[1]), .o_MemAddr_ADDR_W(maddr[1]), .o_MemStoreData_XLEN(mwd1),
        .o_MemStrb_XLEN8(strb1), .i_MemGnt_1(gnt[1]), .i_MemRvalid_1(rvalid[1]),
        .i_MemLoadData_XLEN(rdata[1][31:0]));

    load_store_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut2 (
        .i_Clk_1(clk), .i_Rst_n_1(rst_n), .i_Valid_1(valid[2]), .o_Ready_1(ready[2]),
        .i_Load_1(load[2]), .i_Store_1(store[2]), .i_LoadUnsigned_1(uns[2]),
        .i_LoadStoreWidth_2(width[2]), .i_ALUResult_XLEN(alu[2]),
        .i_StoreData_XLEN(sdata[2]), .o_Done_1(done[2]), .o_GRFWriteData_XLEN(grf2),
        .o_Exception_1(exc[2]), .o_ExcCode_2(code[2]), .o_MemReq_1(req[2]),
        .o_MemWriteEnable_1(we[2]), .o_MemAddr_ADDR_W(maddr[2]), .o_MemStoreData_XLEN(mwd2),
        .o_MemStrb_XLEN8(strb2), .i_MemGnt_1(gnt[2]), .i_MemRvalid_1(rvalid[2]),
        .i_MemLoadData_XLEN(rdata[2]));

    typedef struct {
        int          inst;
        logic        ld, st, un;
        logic [1:0]  w;
        logic [63:0] a, d;
        int          gdly, rdly;
        logic [63:0] r0, r1;
        int          nbeats;
        logic [31:0] ea0;
        logic [7:0]  es0;
        logic [63:0] ed0;
        logic [31:0] ea1;
        logic [7:0]  es1;
        logic [63:0] ed1;
        logic [63:0] eres;
        logic        eexc;
        logic [1:0]  ecode;
        int          elat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic        we;
    } beat_t;

    typedef struct {
        logic [63:0] res;
        logic        exc;
        logic [1:0]  code;
        int          lat;
    } done_t;

    beat_t beat_q [$];
    done_t done_q [$];
    vec_t  vecs [17];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int    k = v.inst;
        int    lat, wcnt, rcnt, bidx, phase;
        bit    finished;
        beat_t eb;
        done_t ed;
        string tag = $sformatf("v%0d", vi);
        @(negedge clk);
        if (v.nbeats >= 1) beat_q.push_back('{v.ea0, v.es0, v.ed0, v.st});
        if (v.nbeats >= 2) beat_q.push_back('{v.ea1, v.es1, v.ed1, v.st});
        done_q.push_back('{v.eres, v.eexc, v.ecode, v.elat});
        valid[k] = 1'b1; load[k] = v.ld; store[k] = v.st; uns[k] = v.un;
        width[k] = v.w;  alu[k] = v.a;   sdata[k] = v.d;
        check({tag, "_ready"}, ready[k], 1'b1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        valid[k] = 1'b0;
        wcnt = 0; rcnt = 0; bidx = 0; phase = 0; finished = 0;
        for (int c = 0; c < 60 && !finished; c++) begin
            gnt[k] = 1'b0;
            rvalid[k] = 1'b0;
            if (done[k]) begin
                ed = done_q.pop_front();
                check({tag, "_result"}, grf[k], ed.res);
                check({tag, "_exc"}, {exc[k], code[k]}, {ed.exc, ed.code});
                check({tag, "_latency"}, 64'(lat), 64'(ed.lat));
                check({tag, "_beats_left"}, 64'(beat_q.size()), 64'd0);
                finished = 1;
            end else begin
                check({tag, "_exc_idle"}, {exc[k], code[k]}, 3'b000);
                if (phase == 1) begin
                    check({tag, "_req_drop"}, req[k], 1'b0);
                    if (rcnt == v.rdly) begin
                        rvalid[k] = 1'b1;
                        rdata[k] = (bidx == 0) ? v.r0 : v.r1;
                        bidx++;
                        phase = 0;
                        rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end else if (req[k]) begin
                    if (beat_q.size() == 0) begin
                        check({tag, "_unexpected_req"}, req[k], 1'b0);
                    end else begin
                        eb = beat_q[0];
                        check({tag, "_addr"}, maddr[k], eb.addr);
                        check({tag, "_strb"}, strb[k], eb.strb);
                        check({tag, "_wdata"}, mwdata[k], eb.wdata);
                        check({tag, "_we"}, we[k], eb.we);
                        if (wcnt == v.gdly) begin
                            gnt[k] = 1'b1;
                            void'(beat_q.pop_front());
                            phase = 1;
                            wcnt = 0;
                        end else begin
                            wcnt++;
                        end
                    end
                end
            end
            if (!finished) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
        if (!finished) check({tag, "_done_timeout"}, done[k], 1'b1);
        gnt[k] = 1'b0;
        rvalid[k] = 1'b0;
        rdata[k] = '0;
        beat_q.delete();
        done_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 0; load[i] = 0; store[i] = 0; uns[i] = 0; gnt[i] = 0; rvalid[i] = 0;
            width[i] = 2'b00; alu[i] = '0; sdata[i] = '0; rdata[i] = '0;
        end

        //          inst ld st un w      addr                   data                   g  r  rdata0                 rdata1                 n  ea0           es0    ed0                    ea1           es1    ed1                    result                 ex ec     lat
        vecs[0]  = '{0, 1, 0, 0, 2'b00, 64'h1003,              64'h0,                 0, 0, 64'h80FF0000,          64'h0,                 1, 32'h1000,     8'h08, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'hFFFFFF80,          0, 2'b00, 3};
        vecs[1]  = '{0, 0, 1, 0, 2'b01, 64'h2002,              64'h0000ABCD,          3, 0, 64'h0,                 64'h0,                 1, 32'h2000,     8'h0C, 64'hABCD0000,          32'h0,        8'h00, 64'h0,                 64'h0,                 0, 2'b00, 6};
        vecs[2]  = '{0, 1, 0, 0, 2'b10, 64'h1001,              64'h0,                 0, 0, 64'h0,                 64'h0,                 0, 32'h0,        8'h00, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'h0,                 1, 2'b01, 1};
        vecs[3]  = '{1, 0, 1, 0, 2'b10, 64'h3FFE,              64'h11223344,          0, 0, 64'h0,                 64'h0,                 2, 32'h3FFC,     8'h0C, 64'h33440000,          32'h4000,     8'h03, 64'h00001122,          64'h0,                 0, 2'b00, 5};
        vecs[4]  = '{2, 1, 0, 0, 2'b11, 64'h8,                 64'h0,                 0, 0, 64'h8000000000000001,  64'h0,                 1, 32'h8,        8'hFF, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'h8000000000000001,  0, 2'b00, 3};
        vecs[5]  = '{0, 1, 0, 0, 2'b11, 64'h0,                 64'h0,                 0, 0, 64'h0,                 64'h0,                 0, 32'h0,        8'h00, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'h0,                 1, 2'b11, 1};
        vecs[6]  = '{0, 0, 0, 0, 2'b00, 64'hDEADBEEF,          64'h12345678,          0, 0, 64'h0,                 64'h0,                 0, 32'h0,        8'h00, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'hDEADBEEF,          0, 2'b00, 1};
        vecs[7]  = '{1, 1, 0, 0, 2'b10, 64'h1001,              64'h0,                 1, 2, 64'hAABBCCDD,          64'h11223344,          2, 32'h1000,     8'h0E, 64'h0,                 32'h1004,     8'h01, 64'h0,                 64'h44AABBCC,          0, 2'b00, 11};
        vecs[8]  = '{1, 1, 0, 1, 2'b01, 64'h3,                 64'h0,                 0, 0, 64'hF0000000,          64'h000000E5,          2, 32'h0,        8'h08, 64'h0,                 32'h4,        8'h01, 64'h0,                 64'h0000E5F0,          0, 2'b00, 5};
        vecs[9]  = '{1, 1, 0, 0, 2'b01, 64'h1,                 64'h0,                 0, 1, 64'h00812300,          64'h0,                 1, 32'h0,        8'h06, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'hFFFF8123,          0, 2'b00, 4};
        vecs[10] = '{2, 1, 0, 0, 2'b11, 64'hC,                 64'h0,                 0, 0, 64'h0,                 64'h0,                 0, 32'h0,        8'h00, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'h0,                 1, 2'b01, 1};
        vecs[11] = '{2, 0, 1, 0, 2'b00, 64'h7,                 64'hFFFFFFFFFFFFFF5A,  2, 0, 64'h0,                 64'h0,                 1, 32'h0,        8'h80, 64'h5A00000000000000,  32'h0,        8'h00, 64'h0,                 64'h0,                 0, 2'b00, 5};
        vecs[12] = '{2, 1, 0, 1, 2'b10, 64'hFFFFFFFC,          64'h0,                 0, 0, 64'h89ABCDEF00000000,  64'h0,                 1, 32'hFFFFFFF8, 8'hF0, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'h0000000089ABCDEF,  0, 2'b00, 3};
        vecs[13] = '{1, 0, 1, 0, 2'b10, 64'hFFFFFFFF,          64'hA1B2C3D4,          0, 0, 64'h0,                 64'h0,                 2, 32'hFFFFFFFC, 8'h08, 64'hD4000000,          32'h0,        8'h07, 64'h00A1B2C3,          64'h0,                 0, 2'b00, 5};
        vecs[14] = '{2, 0, 1, 0, 2'b11, 64'h4,                 64'h0,                 0, 0, 64'h0,                 64'h0,                 0, 32'h0,        8'h00, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'h0,                 1, 2'b10, 1};
        vecs[15] = '{0, 0, 1, 0, 2'b10, 64'h2,                 64'h0,                 0, 0, 64'h0,                 64'h0,                 0, 32'h0,        8'h00, 64'h0,                 32'h0,        8'h00, 64'h0,                 64'h0,                 1, 2'b10, 1};
        vecs[16] = '{2, 1, 0, 0, 2'b01, 64'h7,                 64'h0,                 0, 0, 64'hAB00000000000000,  64'h80,                2, 32'h0,        8'h80, 64'h0,                 32'h8,        8'h01, 64'h0,                 64'hFFFFFFFFFFFF80AB,  0, 2'b00, 5};

        // Outputs while reset is held.
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready%0d", i), ready[i], 1'b1);
            check($sformatf("rst_ctl%0d", i), {done[i], req[i], we[i], exc[i], code[i]}, 6'b0);
            check($sformatf("rst_bus%0d", i), 64'(maddr[i]) | 64'(strb[i]) | mwdata[i] | grf[i], 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Reset while waiting for a response, then a stale response arrives.
        @(negedge clk);
        valid[0] = 1'b1; load[0] = 1'b1; store[0] = 1'b0; uns[0] = 1'b0;
        width[0] = 2'b10; alu[0] = 64'h100; sdata[0] = '0;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        check("rst_seq_req", req[0], 1'b1);
        gnt[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        gnt[0] = 1'b0;
        check("rst_seq_wait_req", req[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_seq_req_async", req[0], 1'b0);
        check("rst_seq_ready_async", ready[0], 1'b1);
        check("rst_seq_done_async", done[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rvalid[0] = 1'b1;
        rdata[0] = 64'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            rvalid[0] = 1'b0;
            check("rst_seq_no_done", done[0], 1'b0);
            check("rst_seq_ready", ready[0], 1'b1);
            check("rst_seq_no_req", req[0], 1'b0);
        end
        rdata[0] = '0;
        run_vec(100, vecs[0]);
        run_vec(101, vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
